// File: rtl/flight_loop_scheduler.sv
// Fixed-rate sequencer for the flight control chain: angle controller ->
// body-frame rate controller -> motor mixer, once per loop period, with a
// per-stage timeout, motor-safe forcing and overrun accounting.
module flight_loop_scheduler #(
  parameter int unsigned LOOP_PERIOD_US   = 2500,
  parameter int unsigned STAGE_TIMEOUT_US = 500
) (
  input  logic        us_clk,
  input  logic        resetn,
  input  logic        loop_enable,
  input  logic        ac_complete,
  input  logic        bf_complete,
  input  logic        mm_complete,
  output logic        ac_start,
  output logic        bf_start,
  output logic        mm_start,
  output logic        loop_busy,
  output logic        loop_done,
  output logic        stage_timeout,
  output logic [1:0]  fault_stage,
  output logic        motor_safe,
  output logic [7:0]  overrun_count,
  output logic [15:0] loop_count,
  output logic [15:0] last_loop_us
);

  localparam int unsigned CW = 16;
  localparam int unsigned OW = 8;
  localparam logic [CW-1:0] PERIOD_LAST  = CW'(LOOP_PERIOD_US - 1);
  // Expiry is flagged on the last allowed wait cycle so the FSM leaves the
  // wait state after exactly STAGE_TIMEOUT_US cycles in it.
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(STAGE_TIMEOUT_US - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_AC_START = 3'd1,
    S_AC_WAIT  = 3'd2,
    S_BF_START = 3'd3,
    S_BF_WAIT  = 3'd4,
    S_MM_START = 3'd5,
    S_MM_WAIT  = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   period_q;
  logic [CW-1:0]   wait_q;
  logic [CW-1:0]   loop_cyc_q;
  logic            pending_q, pending_d;
  logic [1:0]      fault_q, fault_d;
  logic            timeout_d;
  logic            ac_start_q, bf_start_q, mm_start_q;
  logic            loop_busy_q, loop_done_q, stage_timeout_q, motor_safe_q;
  logic [OW-1:0]   overrun_q;
  logic [CW-1:0]   loop_count_q;
  logic [CW-1:0]   last_loop_q;

  logic            tick_c;
  logic            busy_c;
  logic            in_wait_c;
  logic            expire_c;
  logic            overrun_inc_c;
  logic [CW-1:0]   last_loop_c;

  assign tick_c    = (period_q == PERIOD_LAST);
  assign busy_c    = (state_q inside {S_AC_START, S_AC_WAIT, S_BF_START,
                                      S_BF_WAIT, S_MM_START, S_MM_WAIT});
  assign in_wait_c = (state_q inside {S_AC_WAIT, S_BF_WAIT, S_MM_WAIT});
  assign expire_c  = in_wait_c && (wait_q == TIMEOUT_LAST);
  // A tick during a loop, or on top of an already pending loop, is an overrun
  assign overrun_inc_c = tick_c && (busy_c || pending_q) && (overrun_q != '1);
  // Loop length is counted from AC_START entry to DONE entry, saturating
  assign last_loop_c = (loop_cyc_q == '1) ? loop_cyc_q : loop_cyc_q + CW'(1);

  // Free-running loop period counter, independent of loop_enable
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      period_q <= '0;
    end else if (tick_c) begin
      period_q <= '0;
    end else begin
      period_q <= period_q + CW'(1);
    end
  end

  // Next-state, timeout and pending-request logic
  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    fault_d   = fault_q;
    pending_d = pending_q;

    case (state_q)
      S_IDLE: begin
        if ((tick_c || pending_q) && loop_enable) state_d = S_AC_START;
      end
      S_AC_START: state_d = S_AC_WAIT;
      S_AC_WAIT: begin
        if (ac_complete) begin
          state_d = S_BF_START;
        end else if (expire_c) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          fault_d   = 2'd1;
        end
      end
      S_BF_START: state_d = S_BF_WAIT;
      S_BF_WAIT: begin
        if (bf_complete) begin
          state_d = S_MM_START;
        end else if (expire_c) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          fault_d   = 2'd2;
        end
      end
      S_MM_START: state_d = S_MM_WAIT;
      S_MM_WAIT: begin
        if (mm_complete) begin
          state_d = S_DONE;
        end else if (expire_c) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          fault_d   = 2'd3;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A tick that cannot start a loop right away is remembered; a tick in
    // DONE is not an overrun since the loop is already finished.
    if (tick_c && (busy_c || (state_q == S_DONE))) pending_d = 1'b1;
    if (state_d == S_AC_START) pending_d = 1'b0;
    if (!loop_enable)          pending_d = 1'b0;
  end

  // FSM state, stage counters and all registered outputs
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      wait_q          <= '0;
      loop_cyc_q      <= '0;
      pending_q       <= 1'b0;
      fault_q         <= 2'd0;
      ac_start_q      <= 1'b0;
      bf_start_q      <= 1'b0;
      mm_start_q      <= 1'b0;
      loop_busy_q     <= 1'b0;
      loop_done_q     <= 1'b0;
      stage_timeout_q <= 1'b0;
      motor_safe_q    <= 1'b0;
      overrun_q       <= '0;
      loop_count_q    <= '0;
      last_loop_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      fault_q   <= fault_d;

      // Wait counter is zero on entry to each wait state
      wait_q <= in_wait_c ? wait_q + CW'(1) : '0;

      if (state_q == S_IDLE) begin
        loop_cyc_q <= '0;
      end else if (loop_cyc_q != '1) begin
        loop_cyc_q <= loop_cyc_q + CW'(1);
      end

      ac_start_q      <= (state_d == S_AC_START);
      bf_start_q      <= (state_d == S_BF_START);
      mm_start_q      <= (state_d == S_MM_START);
      loop_busy_q     <= (state_d inside {S_AC_START, S_AC_WAIT, S_BF_START,
                                          S_BF_WAIT, S_MM_START, S_MM_WAIT});
      loop_done_q     <= (state_d == S_DONE);
      stage_timeout_q <= timeout_d;

      if (timeout_d) begin
        motor_safe_q <= 1'b1;
      end else if (state_d == S_DONE) begin
        motor_safe_q <= 1'b0;
      end

      if (overrun_inc_c) overrun_q <= overrun_q + OW'(1);

      if (state_d == S_DONE) begin
        loop_count_q <= loop_count_q + CW'(1);
        last_loop_q  <= last_loop_c;
      end
    end
  end

  assign ac_start      = ac_start_q;
  assign bf_start      = bf_start_q;
  assign mm_start      = mm_start_q;
  assign loop_busy     = loop_busy_q;
  assign loop_done     = loop_done_q;
  assign stage_timeout = stage_timeout_q;
  assign fault_stage   = fault_q;
  assign motor_safe    = motor_safe_q;
  assign overrun_count = overrun_q;
  assign loop_count    = loop_count_q;
  assign last_loop_us  = last_loop_q;

endmodule

// File: tb/tb_flight_loop_scheduler.sv
// Directed bench for flight_loop_scheduler with LOOP_PERIOD_US=20,
// STAGE_TIMEOUT_US=8 and a delay-programmable completion responder.
module tb_flight_loop_scheduler;

  logic        us_clk;
  logic        resetn;
  logic        loop_enable;
  logic        ac_complete, bf_complete, mm_complete;
  logic        ac_start, bf_start, mm_start;
  logic        loop_busy, loop_done, stage_timeout;
  logic [1:0]  fault_stage;
  logic        motor_safe;
  logic [7:0]  overrun_count;
  logic [15:0] loop_count;
  logic [15:0] last_loop_us;

  flight_loop_scheduler #(
    .LOOP_PERIOD_US  (20),
    .STAGE_TIMEOUT_US(8)
  ) dut (
    .us_clk       (us_clk),
    .resetn       (resetn),
    .loop_enable  (loop_enable),
    .ac_complete  (ac_complete),
    .bf_complete  (bf_complete),
    .mm_complete  (mm_complete),
    .ac_start     (ac_start),
    .bf_start     (bf_start),
    .mm_start     (mm_start),
    .loop_busy    (loop_busy),
    .loop_done    (loop_done),
    .stage_timeout(stage_timeout),
    .fault_stage  (fault_stage),
    .motor_safe   (motor_safe),
    .overrun_count(overrun_count),
    .loop_count   (loop_count),
    .last_loop_us (last_loop_us)
  );

  initial begin
    us_clk = 1'b0;
    forever #5 us_clk = ~us_clk;
  end

  int total = 0;
  int bad   = 0;

  // Responder controls: completion comes dly cycles after the start pulse
  int ac_dly, bf_dly, mm_dly;
  bit bf_en;
  bit ac_spur;

  // Monitor state: cycle index and last cycle / count of each pulse
  int cyc = 0;
  int n_ac = 0, n_bf = 0, n_mm = 0, n_done = 0, n_to = 0;
  int t_ac = 0, t_bf = 0, t_mm = 0, t_done = 0, t_to = 0;

  localparam int K_AC = 0, K_BF = 1, K_MM = 2, K_DONE = 3, K_TO = 4;

  task automatic chk_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one cycle; land after monitor and responder have run
  task automatic step();
    @(posedge us_clk);
    #2;
  endtask

  function automatic int get_cnt(input int which);
    case (which)
      K_AC:    return n_ac;
      K_BF:    return n_bf;
      K_MM:    return n_mm;
      K_DONE:  return n_done;
      default: return n_to;
    endcase
  endfunction

  task automatic wait_cnt(input string tag, input int which, input int target, input int budget);
    int n = 0;
    while (get_cnt(which) < target && n < budget) begin
      step();
      n++;
    end
    chk_eq(tag, get_cnt(which), target);
  endtask

  // Pulse monitor
  initial begin
    forever begin
      @(posedge us_clk);
      #1;
      cyc++;
      if (ac_start)      begin n_ac++;   t_ac   = cyc; end
      if (bf_start)      begin n_bf++;   t_bf   = cyc; end
      if (mm_start)      begin n_mm++;   t_mm   = cyc; end
      if (loop_done)     begin n_done++; t_done = cyc; end
      if (stage_timeout) begin n_to++;   t_to   = cyc; end
    end
  end

  // Completion responder
  initial begin
    int ac_cnt, bf_cnt, mm_cnt;
    ac_cnt = 0; bf_cnt = 0; mm_cnt = 0;
    ac_complete = 1'b0; bf_complete = 1'b0; mm_complete = 1'b0;
    forever begin
      @(posedge us_clk);
      #1;
      ac_complete = 1'b0; bf_complete = 1'b0; mm_complete = 1'b0;
      if (!resetn) begin
        ac_cnt = 0; bf_cnt = 0; mm_cnt = 0;
      end else begin
        if (ac_cnt > 0) begin ac_cnt--; if (ac_cnt == 0) ac_complete = 1'b1; end
        if (bf_cnt > 0) begin bf_cnt--; if (bf_cnt == 0) bf_complete = 1'b1; end
        if (mm_cnt > 0) begin mm_cnt--; if (mm_cnt == 0) mm_complete = 1'b1; end
        if (ac_start) begin
          ac_cnt = ac_dly;
          if (ac_spur) ac_complete = 1'b1;
        end
        if (bf_start) bf_cnt = bf_en ? bf_dly : 0;
        if (mm_start) mm_cnt = mm_dly;
      end
    end
  end

  // Directed sequence
  initial begin
    int c0, n0, nb, nd, td, r0;
    resetn = 1'b0; loop_enable = 1'b0;
    ac_dly = 3; bf_dly = 3; mm_dly = 3; bf_en = 1'b1; ac_spur = 1'b0;

    repeat (3) step();
    chk_eq("rst_ac_start", int'(ac_start), 0);
    chk_eq("rst_loop_busy", int'(loop_busy), 0);
    chk_eq("rst_motor_safe", int'(motor_safe), 0);
    chk_eq("rst_fault_stage", int'(fault_stage), 0);
    chk_eq("rst_loop_count", int'(loop_count), 0);
    resetn = 1'b1; loop_enable = 1'b1;
    c0 = cyc;

    // Nominal loop: completions 3 cycles after each start
    wait_cnt("nom_ac_seen", K_AC, 1, 40);
    chk_eq("nom_tick_to_start", t_ac - c0, 20);
    wait_cnt("nom_done_seen", K_DONE, 1, 40);
    chk_eq("nom_ac_to_bf", t_bf - t_ac, 4);
    chk_eq("nom_bf_to_mm", t_mm - t_bf, 4);
    chk_eq("nom_mm_to_done", t_done - t_mm, 4);
    chk_eq("nom_loop_count", int'(loop_count), 1);
    chk_eq("nom_last_loop", int'(last_loop_us), 12);
    chk_eq("nom_overrun", int'(overrun_count), 0);
    chk_eq("nom_busy_in_done", int'(loop_busy), 0);

    // BF stage stalls
    bf_en = 1'b0;
    wait_cnt("to_seen", K_TO, 1, 60);
    chk_eq("to_delay", t_to - t_bf, 9);
    chk_eq("to_fault_stage", int'(fault_stage), 2);
    chk_eq("to_motor_safe", int'(motor_safe), 1);
    chk_eq("to_no_mm_start", n_mm, 1);
    chk_eq("to_loop_count", int'(loop_count), 1);
    step();
    chk_eq("to_one_cycle", int'(stage_timeout), 0);

    // Next good loop releases motor_safe, fault_stage stays
    bf_en = 1'b1;
    wait_cnt("rec_done_seen", K_DONE, 2, 60);
    chk_eq("rec_motor_safe", int'(motor_safe), 0);
    chk_eq("rec_fault_stage", int'(fault_stage), 2);
    chk_eq("rec_loop_count", int'(loop_count), 2);

    // Completions on the last allowed wait cycle: loop overruns the period
    ac_dly = 8; bf_dly = 8; mm_dly = 8;
    wait_cnt("race_done_seen", K_DONE, 3, 80);
    chk_eq("race_ac_to_bf", t_bf - t_ac, 9);
    chk_eq("race_bf_to_mm", t_mm - t_bf, 9);
    chk_eq("race_no_timeout", n_to, 1);
    chk_eq("race_last_loop", int'(last_loop_us), 27);
    chk_eq("ovr_count_1", int'(overrun_count), 1);
    td = t_done;
    n0 = n_ac;
    wait_cnt("ovr_restart_seen", K_AC, n0 + 1, 10);
    chk_eq("ovr_done_to_start", t_ac - td, 2);

    // Long run of overrunning loops
    wait_cnt("sat_done_seen", K_DONE, 303, 12000);
    chk_eq("sat_overrun", int'(overrun_count), 255);
    chk_eq("sat_loop_count", int'(loop_count), 303);

    // Drop loop_enable in BF_WAIT
    nb = n_bf;
    wait_cnt("en_bf_seen", K_BF, nb + 1, 60);
    step(); step();
    loop_enable = 1'b0;
    n0 = n_ac;
    nd = n_done;
    wait_cnt("en_loop_finishes", K_DONE, nd + 1, 60);
    chk_eq("en_no_timeout", n_to, 1);
    repeat (80) step();
    chk_eq("en_no_new_start", n_ac, n0);

    // Spurious ac_complete during AC_START
    ac_dly = 3; bf_dly = 3; mm_dly = 3; ac_spur = 1'b1; loop_enable = 1'b1;
    n0 = n_ac;
    wait_cnt("spur_ac_seen", K_AC, n0 + 1, 40);
    nb = n_bf;
    wait_cnt("spur_bf_seen", K_BF, nb + 1, 20);
    chk_eq("spur_ac_to_bf", t_bf - t_ac, 4);
    ac_spur = 1'b0;
    nd = n_done;
    wait_cnt("spur_done_seen", K_DONE, nd + 1, 40);
    chk_eq("spur_last_loop", int'(last_loop_us), 12);
    chk_eq("spur_overrun_held", int'(overrun_count), 255);

    // Reset pulsed mid-AC_WAIT
    n0 = n_ac;
    wait_cnt("rst2_ac_seen", K_AC, n0 + 1, 40);
    step();
    resetn = 1'b0;
    step();
    chk_eq("rst2_loop_busy", int'(loop_busy), 0);
    chk_eq("rst2_overrun", int'(overrun_count), 0);
    chk_eq("rst2_loop_count", int'(loop_count), 0);
    chk_eq("rst2_last_loop", int'(last_loop_us), 0);
    chk_eq("rst2_fault_stage", int'(fault_stage), 0);
    step();
    resetn = 1'b1;
    r0 = cyc;
    n0 = n_ac;
    repeat (19) step();
    chk_eq("rst2_no_early_start", n_ac, n0);
    step();
    chk_eq("rst2_first_start", n_ac, n0 + 1);
    chk_eq("rst2_tick_to_start", t_ac - r0, 20);
    nd = n_done;
    wait_cnt("rst2_done_seen", K_DONE, nd + 1, 40);
    chk_eq("rst2_loop_count_after", int'(loop_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
